// File: rtl/wb_grf_if.sv
// Purpose: bundles the WB-stage write signals, decode read ports and trace drain port of wb_grf.
// Latency: wires only; timing is defined by the register file that uses it.
// Backpressure: trace_ready (from the monitor) is the only flow-control input; writes never stall.
//
// Port summary
//   master : drives RegWriteM/A3M/regdataM/pcM, A1/A2, trace_ready; observes RD1/RD2 and trace_*
//   slave  : the register file side (wb_grf)

interface wb_grf_if;
    // WB-stage write side
    logic        RegWriteM;
    logic [4:0]  A3M;
    logic [31:0] regdataM;
    logic [31:0] pcM;

    // decode read ports
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;

    // trace drain
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_reg;
    logic [31:0] trace_data;
    logic        trace_overflow;

    modport master (
        output RegWriteM, A3M, regdataM, pcM, A1, A2, trace_ready,
        input  RD1, RD2, trace_valid, trace_pc, trace_reg, trace_data, trace_overflow
    );

    modport slave (
        input  RegWriteM, A3M, regdataM, pcM, A1, A2, trace_ready,
        output RD1, RD2, trace_valid, trace_pc, trace_reg, trace_data, trace_overflow
    );
endinterface

// File: rtl/wb_grf.sv
// Purpose: 32x32 general register file with write-through bypass and a trace FIFO of committed writes.
// Latency: reads are combinational (same-cycle bypass); trace records appear one cycle after the write.
// Backpressure: trace drained by valid/ready; when the FIFO is full with no pop the record is dropped and overflow sticks.
//
// Ports
//   clk   : rising-edge clock for all state
//   reset : asynchronous active-low reset, clears registers, FIFO and overflow flag
//   bus   : wb_grf_if.slave - WB write, two read ports, trace drain handshake

module wb_grf #(
    parameter int TRACE_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    wb_grf_if.slave  bus
);

    localparam int              PW      = $clog2(TRACE_DEPTH);
    localparam logic [PW:0]     DEPTH_C = (PW+1)'(TRACE_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } trace_rec_t;

    // ------------------------------------------------------------------
    // Qualified write: $0 is hardwired, so a write to it is a no-op for
    // both the array and the trace stream.
    // ------------------------------------------------------------------
    logic qw;
    assign qw = bus.RegWriteM && (bus.A3M != 5'd0);

    // ------------------------------------------------------------------
    // Register array. Entry 0 is cleared by reset and never written.
    // ------------------------------------------------------------------
    logic [31:0] rf_q [32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (qw) begin
            rf_q[bus.A3M] <= bus.regdataM;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: $0 forced to zero, then the in-flight WB write wins over
    // the array so decode sees the value in the same cycle it commits.
    // ------------------------------------------------------------------
    logic [31:0] rd1_val;
    logic [31:0] rd2_val;

    always_comb begin
        rd1_val = '0;
        if (bus.A1 == 5'd0) begin
            rd1_val = '0;
        end else if (qw && (bus.A1 == bus.A3M)) begin
            rd1_val = bus.regdataM;
        end else begin
            rd1_val = rf_q[bus.A1];
        end
    end

    always_comb begin
        rd2_val = '0;
        if (bus.A2 == 5'd0) begin
            rd2_val = '0;
        end else if (qw && (bus.A2 == bus.A3M)) begin
            rd2_val = bus.regdataM;
        end else begin
            rd2_val = rf_q[bus.A2];
        end
    end

    assign bus.RD1 = rd1_val;
    assign bus.RD2 = rd2_val;

    // ------------------------------------------------------------------
    // Trace FIFO state
    // ------------------------------------------------------------------
    trace_rec_t     fifo_q [TRACE_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]    count_q,  count_d;
    logic           ovf_q,    ovf_d;

    logic           fifo_empty;
    logic           fifo_full;
    logic           pop;
    logic           push;
    logic           drop;
    trace_rec_t     push_rec;
    trace_rec_t     head_rec;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign push_rec   = '{pc: bus.pcM, rd: bus.A3M, data: bus.regdataM};

    always_comb begin
        pop      = 1'b0;
        push     = 1'b0;
        drop     = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        // Pop only ever happens on a visible head, so empty can't underflow.
        pop  = !fifo_empty && bus.trace_ready;
        // A full FIFO still accepts when the head leaves on the same edge.
        push = qw && (!fifo_full || pop);
        drop = qw && fifo_full && !pop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            // Storage is cleared as well so no stale record can ever resurface.
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= push_rec;
            end
        end
    end

    // ------------------------------------------------------------------
    // Trace outputs: head fields are masked to zero while empty so the
    // monitor never sees leftover storage.
    // ------------------------------------------------------------------
    assign head_rec = fifo_q[rd_ptr_q];

    assign bus.trace_valid    = !fifo_empty;
    assign bus.trace_pc       = fifo_empty ? 32'd0 : head_rec.pc;
    assign bus.trace_reg      = fifo_empty ? 5'd0  : head_rec.rd;
    assign bus.trace_data     = fifo_empty ? 32'd0 : head_rec.data;
    assign bus.trace_overflow = ovf_q;

endmodule

// File: tb/tb_wb_grf.sv
// Purpose: self-checking bench for wb_grf with a queue-based reference model and trace scoreboard.
// Latency: inputs driven 1 time unit after the rising edge, reads checked 3 units after, trace checked on falling edge.
// Backpressure: trace_ready is driven per cycle from directed and random patterns.

module tb_wb_grf;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } rec_t;

    logic clk;
    logic reset;

    wb_grf_if bus ();

    wb_grf #(.TRACE_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register values, FIFO occupancy,
    // sticky overflow, and the ordered list of records the monitor must see.
    logic [31:0] rf_m [32];
    int          occ_m;
    bit          ovf_m;
    rec_t        sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                               input logic [4:0] a3, input logic [31:0] d);
        if (a == 5'd0)               return 32'd0;
        if (we && a3 != 5'd0 && a == a3) return d;
        return rf_m[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
        occ_m = 0;
        ovf_m = 1'b0;
        sb.delete();
    endtask

    // One clock cycle of stimulus; checks combinational outputs, then
    // advances the model to what the upcoming edge should produce.
    task automatic step(input logic we, input logic [4:0] a3, input logic [31:0] d,
                        input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                        input logic rdy);
        bit   qw;
        bit   pop;
        rec_t r;
        @(posedge clk);
        #1;
        bus.RegWriteM   = we;
        bus.A3M         = a3;
        bus.regdataM    = d;
        bus.pcM         = pc;
        bus.A1          = a1;
        bus.A2          = a2;
        bus.trace_ready = rdy;
        #2;
        chk("RD1",            bus.RD1, model_read(a1, we, a3, d));
        chk("RD2",            bus.RD2, model_read(a2, we, a3, d));
        chk("trace_valid",    32'(bus.trace_valid), 32'(occ_m != 0));
        chk("trace_overflow", 32'(bus.trace_overflow), 32'(ovf_m));

        qw  = we && (a3 != 5'd0);
        pop = (occ_m > 0) && rdy;
        if (qw) begin
            rf_m[a3] = d;
            if (occ_m < DEPTH || pop) begin
                r.pc = pc; r.rd = a3; r.data = d;
                sb.push_back(r);
                occ_m++;
            end else begin
                ovf_m = 1'b1;
            end
        end
        if (pop) occ_m--;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2, input logic rdy);
        step(1'b0, 5'd0, 32'd0, 32'd0, a1, a2, rdy);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        @(posedge clk);
        #1;
        bus.RegWriteM   = 1'b0;
        bus.A1          = 5'd5;
        bus.A2          = 5'd31;
        bus.trace_ready = 1'b0;
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        chk("rst_trace_valid", 32'(bus.trace_valid), 32'd0);
        chk("rst_overflow",    32'(bus.trace_overflow), 32'd0);
        chk("rst_RD1_a5",      bus.RD1, 32'd0);
        chk("rst_RD2_a31",     bus.RD2, 32'd0);
        chk("rst_trace_pc",    bus.trace_pc, 32'd0);
        chk("rst_trace_reg",   32'(bus.trace_reg), 32'd0);
        chk("rst_trace_data",  bus.trace_data, 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Trace monitor: the head must always equal the oldest expected record;
    // a handshake on this cycle retires it.
    always @(negedge clk) begin
        if (bus.trace_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL trace_unexpected: got pc=%h reg=%0d data=%h expected no record",
                         bus.trace_pc, bus.trace_reg, bus.trace_data);
            end else begin
                if (bus.trace_pc !== sb[0].pc || bus.trace_reg !== sb[0].rd ||
                    bus.trace_data !== sb[0].data) begin
                    errors++;
                    $display("FAIL trace_head: got pc=%h reg=%0d data=%h expected pc=%h reg=%0d data=%h",
                             bus.trace_pc, bus.trace_reg, bus.trace_data,
                             sb[0].pc, sb[0].rd, sb[0].data);
                end
                if (bus.trace_ready) void'(sb.pop_front());
            end
        end else begin
            checks++;
            if (bus.trace_pc !== 32'd0 || bus.trace_reg !== 5'd0 || bus.trace_data !== 32'd0) begin
                errors++;
                $display("FAIL trace_empty_fields: got pc=%h reg=%0d data=%h expected all zero",
                         bus.trace_pc, bus.trace_reg, bus.trace_data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        reset           = 1'b0;
        bus.RegWriteM   = 1'b0;
        bus.A3M         = 5'd0;
        bus.regdataM    = 32'd0;
        bus.pcM         = 32'd0;
        bus.A1          = 5'd5;
        bus.A2          = 5'd31;
        bus.trace_ready = 1'b0;
        #2;
        chk("init_RD1",         bus.RD1, 32'd0);
        chk("init_RD2",         bus.RD2, 32'd0);
        chk("init_trace_valid", 32'(bus.trace_valid), 32'd0);
        chk("init_overflow",    32'(bus.trace_overflow), 32'd0);
        #10;
        reset = 1'b1;

        // Write and bypass, then array read on the next cycle.
        step(1'b1, 5'd8, 32'h1234_5678, 32'h0000_1000, 5'd8, 5'd0, 1'b1);
        idle(5'd8, 5'd8, 1'b1);
        idle(5'd8, 5'd0, 1'b1);

        // $0 stays zero and produces no trace record.
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_2000, 5'd0, 5'd0, 1'b1);
        idle(5'd0, 5'd8, 1'b1);

        // Fill the FIFO in order with the monitor stalled.
        for (int i = 1; i <= 4; i++)
            step(1'b1, 5'(i), 32'(i), 32'h3000 + 32'(4 * (i - 1)), 5'(i), 5'd0, 1'b0);
        idle(5'd1, 5'd4, 1'b0);

        // Overflow: record dropped, array still written, flag sticks through drain.
        step(1'b1, 5'd9, 32'h0000_00AB, 32'h0000_4000, 5'd9, 5'd0, 1'b0);
        idle(5'd9, 5'd4, 1'b0);
        for (int i = 0; i < 6; i++) idle(5'd9, 5'd1, 1'b1);

        // Reset with two buffered records.
        step(1'b1, 5'd5,  32'hDEAD_0005, 32'h5000, 5'd5, 5'd31, 1'b0);
        step(1'b1, 5'd31, 32'hDEAD_001F, 32'h5004, 5'd5, 5'd31, 1'b0);
        idle(5'd5, 5'd31, 1'b0);
        reset_pulse();
        idle(5'd5, 5'd31, 1'b1);

        // Full FIFO with simultaneous push and pop.
        for (int i = 1; i <= 4; i++)
            step(1'b1, 5'(i + 10), 32'h100 + 32'(i), 32'h6000 + 32'(4 * i), 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd10, 32'h0000_0055, 32'h0000_7000, 5'd10, 5'd11, 1'b1);
        idle(5'd10, 5'd11, 1'b0);
        for (int i = 0; i < 5; i++) idle(5'd10, 5'd14, 1'b1);

        // Randomized traffic with bursty backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] a3;
            logic [4:0] a1;
            logic [4:0] a2;
            a3 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 1) == 0) ? a3 : 5'($urandom_range(0, 7));
            a2 = 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 2) != 0), a3, $urandom, $urandom, a1, a2,
                 1'(((i / 16) % 3 == 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0)));
        end

        // Drain whatever remains, bounded.
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(5'd1, 5'd2, 1'b1);
        idle(5'd3, 5'd4, 1'b1);
        @(negedge clk);
        #1;
        chk("final_drain_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_grf.md
# wb_grf

Write-back end of the MEM/WB pipeline register: a 32×32 general register file written from the WB-stage signals, with two read ports for the decode stage. Reads see a same-cycle write through an internal bypass. Every committed register write is also pushed into a small trace FIFO, which a valid/ready handshake drains to the simulation monitor. The block sits directly downstream of the MEM/WB register and feeds the ID stage's operand muxes.

## Interface
Parameters:
- TRACE_DEPTH, 4, trace FIFO entries; power of two, ≥2

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- RegWriteM  input  1  WB-stage write enable
- A3M  input  5  WB-stage destination register
- regdataM  input  32  WB-stage write data
- pcM  input  32  PC of the writing instruction
- A1  input  5  read port 1 address
- A2  input  5  read port 2 address
- RD1  output  32  read port 1 data, combinational
- RD2  output  32  read port 2 data, combinational
- trace_valid  output  1  FIFO head holds a record
- trace_ready  input  1  monitor accepts the head record
- trace_pc  output  32  head record PC
- trace_reg  output  5  head record register number
- trace_data  output  32  head record data
- trace_overflow  output  1  sticky flag: a record was dropped

## Operation
- Qualified write (qw) = RegWriteM && (A3M != 0).
- Register array:
  - On qw, the array entry at A3M is written with regdataM at the clock edge.
  - $0 is never written and always reads 0.
- Read ports:
  - RDn = 0 if An == 0.
  - Otherwise RDn = regdataM if qw && An == A3M.
  - Otherwise RDn = array[An].
- Trace FIFO:
  - A push occurs on qw, storing {pcM, A3M, regdataM}.
  - A pop occurs when trace_valid && trace_ready.
  - The FIFO keeps read/write pointers of log2(TRACE_DEPTH) bits that wrap modulo TRACE_DEPTH, plus a count of 0..TRACE_DEPTH.
- FIFO boundary cases:
  - Push and pop in the same cycle when not empty: both happen and count is unchanged. This includes the full case.
  - Push when full with no pop: the record is dropped, the pointers are unchanged and trace_overflow sets. The register array is still written.
  - Pop when empty is impossible, because trace_valid = 0.
  - Push when empty with trace_ready high: no same-cycle fall-through. The record appears the next cycle.
- trace_overflow stays at 1 until reset.
- trace_valid = (count != 0).
- trace_pc, trace_reg and trace_data show the head entry while trace_valid = 1, and read 0 while empty.
- A non-qualified write (RegWriteM = 0, or A3M = 0) changes neither the array nor the FIFO.

## Timing
- Reset (reset = 0) takes effect immediately, independent of clk. It clears:
  - all 32 registers to 0;
  - both FIFO pointers and count to 0;
  - trace_valid = 0 and trace_overflow = 0;
  - trace_pc/reg/data = 0.
- RD1/RD2 are combinational from A1, A2, the array and the bypass terms.
- While reset is low, RD1/RD2 read 0 for all addresses (array cleared, bypass still active on qw).
- Writes are ignored while reset = 0.
- Reset asserted mid-operation discards all buffered trace records and all register contents. No partial state survives.
- Write latency:
  - a value is visible through the bypass in the same cycle as qw;
  - it is visible from the array from the cycle after the edge.
- Trace latency: trace_valid rises the cycle after the first push into an empty FIFO.
- Handshake: the head advances on each rising edge where trace_valid && trace_ready. The monitor may hold trace_ready high continuously, giving a throughput of 1 record/cycle.
- The head record's fields stay stable while trace_valid && !trace_ready.

## Test plan
- Reset then read: pulse reset low mid-cycle while the FIFO holds 2 records -> outputs clear immediately with no clk edge. Afterwards RD1 = RD2 = 0 for A1 = 5, A2 = 31, and trace_valid = 0.
- Write and bypass: qw to $8 with 0x1234_5678 while A1 = 8 -> RD1 = 0x1234_5678 in the same cycle. Next cycle with RegWriteM = 0 -> RD1 still 0x1234_5678.
- $0 protection: RegWriteM = 1, A3M = 0, data 0xFFFF_FFFF, A1 = 0 -> RD1 = 0 in the write cycle and after; no trace record.
- Trace ordering: trace_ready = 0, writes to $1..$4 with data 1..4 and pc 0x3000, 0x3004, 0x3008, 0x300C -> FIFO full, trace_overflow = 0. Then raise trace_ready -> records pop in order over 4 cycles (reg 1..4, pc 0x3000..0x300C); trace_valid falls after the 4th.
- Overflow: with the FIFO full and trace_ready = 0, a write to $9 of 0xAB -> trace_overflow = 1 and the record is dropped. RD1 with A1 = 9 reads 0xAB. trace_overflow remains 1 after the FIFO drains.
- Full simultaneous push/pop: FIFO full, trace_ready = 1, qw to $10 with data 0x55 -> head pops and the new record is accepted. Count stays 4, trace_overflow stays 0, and $10/0x55 emerges as the last of the next 4 records.
